// File: rtl/h_cw_deserializer_12.sv
// Serial-to-parallel front end for the 12-bit SECDED Hamming decoder.
// Hunts for a start-of-frame strobe and shifts in CW_WIDTH bits MSB-first.
// Completed words are parked in a one-entry output register with a valid/ready
// handshake, and that register drives the decoder codeword input directly.
// Framing aborts (Sof mid-frame, inter-bit timeout) and overrun drops are
// reported as one-cycle registered pulses. A saturating counter tallies drops.
module h_cw_deserializer_12 #(
  parameter int CW_WIDTH = 12,
  parameter int TIMEOUT  = 16,
  parameter int DROP_W   = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_SerData,
  input  logic                i_SerValid,
  input  logic                i_Sof,
  output logic [CW_WIDTH-1:0] o_CodeWord,
  output logic                o_CwValid,
  input  logic                i_CwReady,
  output logic                o_FrameErr,
  output logic                o_Overrun,
  output logic [DROP_W-1:0]   o_DropCnt
);

  localparam int CNT_W = $clog2(CW_WIDTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  // Only the first CW_WIDTH-1 bits are ever stored; the last bit is taken
  // straight from the line when the word completes.
  logic [CW_WIDTH-2:0] shift_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [TMR_W-1:0]    idle_tmr;

  logic                sof_strobe;
  logic                complete;
  logic                restart;
  logic                timeout;
  logic                load;
  logic                drop;
  logic [CW_WIDTH-1:0] word_next;

  // Decode the events of this cycle from the FSM state and the serial inputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    sof_strobe = 1'b0;
    complete   = 1'b0;
    restart    = 1'b0;
    timeout    = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    word_next  = {shift_q, i_SerData};

    sof_strobe = i_SerValid & i_Sof;
    if (state == SHIFT) begin
      // Completion wins over a Sof flag riding on the last bit.
      complete = i_SerValid && (bit_cnt == CNT_W'(CW_WIDTH - 1));
      restart  = sof_strobe && !complete;
      timeout  = !i_SerValid && (idle_tmr == TMR_W'(TIMEOUT - 1));
    end
    // A completed word lands only if the register is empty or being drained
    // in this very cycle; otherwise it is lost.
    load = complete && (!o_CwValid || i_CwReady);
    drop = complete && o_CwValid && !i_CwReady;
  end

  // Framing FSM: hunt for Sof, collect bits, abort on restart or timeout.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      idle_tmr   <= '0;
      o_FrameErr <= 1'b0;
    end else begin
      o_FrameErr <= 1'b0;
      case (state)
        IDLE: begin
          idle_tmr <= '0;
          if (sof_strobe) begin
            shift_q <= {{(CW_WIDTH - 2){1'b0}}, i_SerData};
            bit_cnt <= CNT_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_SerValid) begin
            idle_tmr <= '0;
            if (complete) begin
              shift_q <= '0;
              bit_cnt <= '0;
              state   <= IDLE;
            end else if (restart) begin
              o_FrameErr <= 1'b1;
              shift_q    <= {{(CW_WIDTH - 2){1'b0}}, i_SerData};
              bit_cnt    <= CNT_W'(1);
            end else begin
              shift_q <= word_next[CW_WIDTH-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timeout) begin
            o_FrameErr <= 1'b1;
            shift_q    <= '0;
            bit_cnt    <= '0;
            idle_tmr   <= '0;
            state      <= IDLE;
          end else begin
            idle_tmr <= idle_tmr + 1'b1;
          end
        end
        default: begin
          shift_q  <= '0;
          bit_cnt  <= '0;
          idle_tmr <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // One-entry output register with valid/ready handshake and overrun tally.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_CodeWord <= '0;
      o_CwValid  <= 1'b0;
      o_Overrun  <= 1'b0;
      o_DropCnt  <= '0;
    end else begin
      o_Overrun <= drop;
      if (load) begin
        o_CodeWord <= word_next;
        o_CwValid  <= 1'b1;
      end else if (o_CwValid && i_CwReady) begin
        // Accepted: the word stays on the bus, only valid drops.
        o_CwValid <= 1'b0;
      end
      if (drop && (o_DropCnt != '1)) begin
        o_DropCnt <= o_DropCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_h_cw_deserializer_12.sv
// Directed bench for h_cw_deserializer_12: hand-computed vectors covering
// reset, normal frames, overrun, Sof restart, timeout, gapped strobes and
// asynchronous reset mid-frame / with a pending word.
module tb_h_cw_deserializer_12;

  localparam int CW_WIDTH = 12;
  localparam int TIMEOUT  = 16;
  localparam int DROP_W   = 8;

  logic                clk;
  logic                rst_n;
  logic                ser_data;
  logic                ser_valid;
  logic                sof;
  logic [CW_WIDTH-1:0] code_word;
  logic                cw_valid;
  logic                cw_ready;
  logic                frame_err;
  logic                overrun;
  logic [DROP_W-1:0]   drop_cnt;

  int n_vec;
  int n_err;
  int fe_seen;

  h_cw_deserializer_12 #(
    .CW_WIDTH(CW_WIDTH),
    .TIMEOUT (TIMEOUT),
    .DROP_W  (DROP_W)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_SerData (ser_data),
    .i_SerValid(ser_valid),
    .i_Sof     (sof),
    .o_CodeWord(code_word),
    .o_CwValid (cw_valid),
    .i_CwReady (cw_ready),
    .o_FrameErr(frame_err),
    .o_Overrun (overrun),
    .o_DropCnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame-error pulses; each registered pulse is seen at exactly one edge.
  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All drive/sample activity happens 1 time unit after a rising edge.
  task automatic idle_cycle();
    ser_valid = 1'b0;
    sof       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic d, input logic s);
    ser_valid = 1'b1;
    ser_data  = d;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  // Send word[hi] down to word[lo], Sof on the first bit if requested,
  // with 'gap' idle cycles between bits (not after the last one).
  task automatic send_range(input logic [CW_WIDTH-1:0] word, input int hi, input int lo,
                            input int gap, input logic sof_first);
    for (int i = hi; i >= lo; i--) begin
      drive_bit(word[i], sof_first && (i == hi));
      if (i != lo) repeat (gap) idle_cycle();
    end
    ser_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic do_reset();
    ser_valid = 1'b0;
    sof       = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " word"},  16'(code_word), 16'h000);
    check({tag, " valid"}, 16'(cw_valid),  16'h0);
    check({tag, " ferr"},  16'(frame_err), 16'h0);
    check({tag, " ovr"},   16'(overrun),   16'h0);
    check({tag, " drops"}, 16'(drop_cnt),  16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    fe_seen   = 0;
    rst_n     = 1'b0;
    ser_data  = 1'b0;
    ser_valid = 1'b0;
    sof       = 1'b0;
    cw_ready  = 1'b1;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1) Basic frame 12'hAAA with ready held high; latency exactly one clock.
    send_range(12'hAAA, 11, 1, 0, 1'b1);
    check("aaa valid before last", 16'(cw_valid), 16'h0);
    drive_bit(1'b0, 1'b0);
    ser_valid = 1'b0;
    check("aaa valid", 16'(cw_valid), 16'h1);
    check("aaa word", 16'(code_word), 16'hAAA);
    idle_cycle();
    check("aaa valid cleared", 16'(cw_valid), 16'h0);
    check("aaa word held", 16'(code_word), 16'hAAA);

    // 2) Overrun: ready low, second word is dropped.
    cw_ready = 1'b0;
    send_range(12'h5A5, 11, 0, 0, 1'b1);
    check("ovr first valid", 16'(cw_valid), 16'h1);
    check("ovr first word", 16'(code_word), 16'h5A5);
    send_range(12'h0F0, 11, 0, 0, 1'b1);
    check("ovr pulse", 16'(overrun), 16'h1);
    check("ovr drops", 16'(drop_cnt), 16'h01);
    check("ovr word kept", 16'(code_word), 16'h5A5);
    check("ovr valid kept", 16'(cw_valid), 16'h1);
    idle_cycle();
    check("ovr pulse end", 16'(overrun), 16'h0);
    cw_ready = 1'b1;
    idle_cycle();
    check("ovr drained", 16'(cw_valid), 16'h0);
    check("ovr drops hold", 16'(drop_cnt), 16'h01);

    // 3) Sof mid-frame after 5 bits restarts the frame with 12'h123.
    do_reset();
    fe_seen = 0;
    send_range(12'hFFF, 11, 7, 0, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("restart ferr", 16'(frame_err), 16'h1);
    send_range(12'h123, 10, 0, 0, 1'b0);
    check("restart ferr count", 16'(fe_seen), 16'd1);
    check("restart word", 16'(code_word), 16'h123);
    check("restart valid", 16'(cw_valid), 16'h1);
    check("restart drops", 16'(drop_cnt), 16'h00);
    idle_cycle();

    // 4) Timeout after 7 bits: abort exactly at the 16th idle cycle.
    do_reset();
    send_range(12'hABC, 11, 5, 0, 1'b1);
    repeat (TIMEOUT - 1) idle_cycle();
    check("tmo not yet", 16'(frame_err), 16'h0);
    idle_cycle();
    check("tmo ferr", 16'(frame_err), 16'h1);
    idle_cycle();
    check("tmo pulse end", 16'(frame_err), 16'h0);
    for (int i = 0; i < CW_WIDTH; i++) drive_bit(1'b1, 1'b0);
    ser_valid = 1'b0;
    idle_cycle();
    check("tmo no sof no word", 16'(cw_valid), 16'h0);
    check("tmo word zero", 16'(code_word), 16'h000);

    // 5) Gapped strobes: 3 idle cycles, and the 15-cycle boundary, no timeout.
    fe_seen = 0;
    send_range(12'hFFF, 11, 0, 3, 1'b1);
    check("gap3 word", 16'(code_word), 16'hFFF);
    check("gap3 valid", 16'(cw_valid), 16'h1);
    idle_cycle();
    send_range(12'h3C3, 11, 0, TIMEOUT - 1, 1'b1);
    check("gap15 word", 16'(code_word), 16'h3C3);
    check("gap no ferr", 16'(fe_seen), 16'd0);
    idle_cycle();
    // Single-bit-flipped codeword for the decoder: odd overall parity.
    send_range(12'hFFE, 11, 0, 0, 1'b1);
    check("flip word", 16'(code_word), 16'hFFE);
    check("flip parity odd", 16'(^code_word), 16'h1);
    idle_cycle();

    // 6) Async reset mid-frame, then with a pending word and a drop recorded.
    send_range(12'hFFF, 11, 6, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst midframe");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cw_ready = 1'b0;
    send_range(12'h7E7, 11, 0, 0, 1'b1);
    send_range(12'h111, 11, 0, 0, 1'b1);
    check("rst pre drops", 16'(drop_cnt), 16'h01);
    send_range(12'h222, 11, 4, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst pending");
    rst_n = 1'b1;
    cw_ready = 1'b1;
    @(posedge clk);
    #1;
    // Bits left over from the interrupted frame must not leak into this one.
    send_range(12'h001, 11, 0, 0, 1'b1);
    check("post rst word", 16'(code_word), 16'h001);
    check("post rst valid", 16'(cw_valid), 16'h1);
    idle_cycle();
    check("post rst drained", 16'(cw_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
